dmem_dump_reader: RTL and testbench

//   Reads back a contiguous window of RISCV_32 data memory (D_Mem) after the core halts.

---
 rtl/riscv_dump_pkg.sv | 17 +
 rtl/dmem_dump_reader.sv | 135 +++++++++++++
 tb/tb_dmem_dump_reader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dump_pkg.sv
// Shared types and default widths for the D_Mem dump reader.
package riscv_dump_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 10;
  localparam int unsigned DefCntW  = 11;

  typedef enum logic [2:0] {
    StIdle,
    StWaitHalt,
    StRead,
    StCapture,
    StSend,
    StDone
  } dump_state_e;

endpackage

// File: rtl/dmem_dump_reader.sv
// Streams a window of D_Mem as address/data beats once the core is halted.
// Optional running checksum output enabled by `define DUMP_CHECKSUM_EN.
module dmem_dump_reader
  import riscv_dump_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              halted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              start_accept;
  logic              handshake;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_addr_d  = base_addr;
          remaining_d = count;
          state_d     = StWaitHalt;
        end
      end
      StWaitHalt: begin
        if (halted) begin
          state_d = (remaining_q == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        // Never touch the shared read port while the core may own it.
        if (halted) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        out_data_d = mem_rd_data;
        out_addr_d = cur_addr_q;
        state_d    = StSend;
      end
      StSend: begin
        if (out_ready) begin
          remaining_d = remaining_q - CNT_W'(1);
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          state_d     = (remaining_q == CNT_W'(1)) ? StDone : StRead;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign start_accept = (state_q == StIdle) && start;
  assign handshake    = (state_q == StSend) && out_ready;

  assign mem_rd_en = (state_q == StRead) && halted;
  assign mem_addr  = cur_addr_q;
  assign out_valid = (state_q == StSend);
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = (state_q == StSend) && (remaining_q == CNT_W'(1));
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk1) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (start_accept) begin
      checksum_q <= '0;
    end else if (handshake) begin
      checksum_q <= checksum_q + out_data_q;
    end
  end

  assign checksum = checksum_q;
`else
  logic unused_start_accept;
  logic unused_handshake;
  assign unused_start_accept = start_accept;
  assign unused_handshake    = handshake;
`endif

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench for dmem_dump_reader: table of dump windows plus a reset-abort sequence.
module tb_dmem_dump_reader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 11;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] count;
  logic          halted;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef DUMP_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  dmem_dump_reader dut (
    .clk1        (clk1),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .halted      (halted),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
`ifdef DUMP_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk1 = ~clk1;

  // D_Mem model: one-cycle read latency.
  logic [DW-1:0] dmem [0:1023];
  always @(posedge clk1) begin
    if (mem_rd_en) mem_rd_data <= dmem[mem_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            base;
    int            cnt;
    int            halt_dly;
    int            stall;
    bit            spurious;
    logic [DW-1:0] exp_sum;
    logic [AW-1:0] exp_last_addr;
  } vec_t;

  task automatic run_dump(input vec_t v);
    int            beats     = 0;
    int            dones     = 0;
    int            rds       = 0;
    int            done_cyc  = -1;
    int            stall_cnt = 0;
    bit            held      = 0;
    bit            finished  = 0;
    logic [DW-1:0] hd;
    logic [AW-1:0] ha;
    logic          hl;
    logic [AW-1:0] ea;
    @(posedge clk1); #1;
    base_addr = AW'(v.base);
    count     = CW'(v.cnt);
    start     = 1'b1;
    halted    = (v.halt_dly == 0);
    out_ready = 1'b0;
    @(posedge clk1); #1;
    for (int cyc = 1; cyc < 3000 && !finished; cyc++) begin
      halted = (cyc >= v.halt_dly);
      if (v.spurious && cyc == 6) begin
        start = 1'b1; base_addr = '0; count = CW'(2);
      end else begin
        start = 1'b0;
      end
      if (v.stall == 0) begin
        out_ready = 1'b1;
      end else if (beats == 2 && stall_cnt < 10) begin
        out_ready = 1'b0;
        if (out_valid) stall_cnt++;
      end else begin
        out_ready = (cyc % 2 == 0);
      end
      #1;
      if (mem_rd_en) begin
        rds++;
        if (!halted) check("rd_en_while_running", 1, 0);
      end
      if (out_valid) begin
        if (held) begin
          check("hold_data", out_data, hd);
          check("hold_addr", out_addr, ha);
          check("hold_last", out_last, hl);
        end
        if (out_ready) begin
          ea = AW'((v.base + beats) % 1024);
          check("beat_addr", out_addr, ea);
          check("beat_data", out_data, dmem[ea]);
          check("beat_last", out_last, (beats == v.cnt - 1));
          if (beats == v.cnt - 1) check("last_addr", out_addr, v.exp_last_addr);
          beats++;
          held = 0;
        end else begin
          held = 1; hd = out_data; ha = out_addr; hl = out_last;
        end
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
`ifdef DUMP_CHECKSUM_EN
        check("checksum", checksum, v.exp_sum);
`endif
        finished = 1;
      end
      @(posedge clk1); #1;
    end
    if (!finished) check("dump_timeout", 0, 1);
    out_ready = 1'b0;
    start     = 1'b0;
    #1;
    check("idle_after_done_busy", busy, 0);
    check("idle_after_done_pulse", done, 0);
`ifdef DUMP_CHECKSUM_EN
    check("checksum_held", checksum, v.exp_sum);
`endif
    check("beat_count", beats, v.cnt);
    check("done_pulses", dones, 1);
    check("read_count", rds, v.cnt);
    if (v.cnt == 0) check("zero_count_done_fast", (done_cyc <= 3), 1);
  endtask

  vec_t vecs [4];
  vec_t post;

  initial begin
    int beats;
    bit hit;
    for (int i = 0; i < 1024; i++) dmem[i] = 32'h5a000000 | i;
    dmem[200] = 32'd10; dmem[201] = 32'd9;  dmem[202] = 32'd7;  dmem[203] = 32'd12;
    dmem[204] = 32'd30; dmem[205] = 32'd9;  dmem[206] = 32'hffffffff;
    dmem[1022] = 32'hdead0001; dmem[1023] = 32'hdead0002;
    dmem[0] = 32'h11111111; dmem[1] = 32'h22222222; dmem[2] = 32'h33333333;
    dmem[3] = 32'h44444444; dmem[4] = 32'h55555555;

    vecs[0] = '{base: 200,  cnt: 7, halt_dly: 40, stall: 0, spurious: 1,
                exp_sum: 32'h4c, exp_last_addr: 10'd206};
    vecs[1] = '{base: 200,  cnt: 7, halt_dly: 40, stall: 1, spurious: 1,
                exp_sum: 32'h4c, exp_last_addr: 10'd206};
    vecs[2] = '{base: 200,  cnt: 0, halt_dly: 0,  stall: 0, spurious: 0,
                exp_sum: 32'h0, exp_last_addr: 10'd0};
    vecs[3] = '{base: 1022, cnt: 3, halt_dly: 0,  stall: 0, spurious: 0,
                exp_sum: 32'hce6b1114, exp_last_addr: 10'd0};
    post    = '{base: 0,    cnt: 1, halt_dly: 0,  stall: 0, spurious: 0,
                exp_sum: 32'h11111111, exp_last_addr: 10'd0};

    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; halted = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
`ifdef DUMP_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_dump(vecs[i]);

    // Abort in SEND of beat 2 of 5, then a fresh one-word dump.
    @(posedge clk1); #1;
    base_addr = '0; count = CW'(5); start = 1'b1; halted = 1'b1; out_ready = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    beats = 0;
    hit   = 0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      if (out_valid && beats == 1) begin
        out_ready = 1'b0;
        rst       = 1'b1;
        hit       = 1;
      end else begin
        if (out_valid) beats++;
        @(posedge clk1); #1;
      end
    end
    if (!hit) check("abort_reach_send", 0, 1);
    @(posedge clk1); #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_last", out_last, 0);
    check("abort_rd_en", mem_rd_en, 0);
    rst = 1'b0;
    run_dump(post);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
